// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: opcode constants,
// instruction field helpers, FSM state encoding and the bundle of pipeline
// control enables produced each cycle.
package pipeline_hazard_ctrl_pkg;

   localparam logic [3:0] OP_R    = 4'd0;
   localparam logic [3:0] OP_BEQ  = 4'd2;
   localparam logic [3:0] OP_ADDI = 4'd3;
   localparam logic [3:0] OP_LW   = 4'd5;
   localparam logic [3:0] OP_SW   = 4'd6;
   localparam logic [3:0] OP_J    = 4'd7;
   localparam logic [3:0] OP_JAL  = 4'd8;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERROR    = 2'd2
   } ctrlState_e;

   // Per-cycle pipeline enables, kept together so the output mux is one struct.
   typedef struct packed {
      logic pcWrite;
      logic ifIdWrite;
      logic ifIdFlush;
      logic idExBubble;
      logic pipeHold;
      logic memWbBubble;
      logic dmemReq;
   } pipeCtrl_t;

   function automatic logic [3:0] opcodeOf(input logic [15:0] instr);
      return instr[15:12];
   endfunction

   function automatic logic [2:0] rsOf(input logic [15:0] instr);
      return instr[11:9];
   endfunction

   function automatic logic [2:0] rtOf(input logic [15:0] instr);
      return instr[8:6];
   endfunction

   // Only R-type, BEQ and SW actually read rt as a source.
   function automatic logic readsRt(input logic [3:0] op);
      return (op == OP_R) || (op == OP_BEQ) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of decoder-side inputs and pipeline-register enables for the hazard
// controller. master: the controller itself; slave: the surrounding pipeline.
//   inputs : if_id_instr, id_ex_memread, id_ex_rt, ex_branch_taken,
//            ex_mem_access, dmem_ready
//   outputs: pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
//            mem_wb_bubble, dmem_req, mem_err, stall_cycles[CNT_W]
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [15:0]      if_id_instr;
   logic             id_ex_memread;
   logic [2:0]       id_ex_rt;
   logic             ex_branch_taken;
   logic             ex_mem_access;
   logic             dmem_ready;
   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic             pipe_hold;
   logic             mem_wb_bubble;
   logic             dmem_req;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      input  if_id_instr, id_ex_memread, id_ex_rt, ex_branch_taken,
             ex_mem_access, dmem_ready,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
             mem_wb_bubble, dmem_req, mem_err, stall_cycles
   );

   modport slave (
      output if_id_instr, id_ex_memread, id_ex_rt, ex_branch_taken,
             ex_mem_access, dmem_ready,
      input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
             mem_wb_bubble, dmem_req, mem_err, stall_cycles
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_lu_hazard_cmp.sv
// Combinational load-use detector.
//   instr   : instruction in IF/ID
//   idExRt  : destination register of the load in EX
//   memRead : EX instruction is a load
//   hit     : IF/ID instruction consumes the load result next cycle
module lu_hazard_cmp
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic [15:0] instr,
   input  logic [2:0]  idExRt,
   input  logic        memRead,
   output logic        hit
);
   logic srcMatch;

   // rt only counts as a source for opcodes that read it; a NOP never hazards.
   assign srcMatch = (idExRt == rsOf(instr)) ||
                     ((idExRt == rtOf(instr)) && readsRt(opcodeOf(instr)));
   assign hit = memRead && (idExRt != 3'd0) && (instr != 16'h0000) && srcMatch;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage 16-bit pipeline. Handles load-use
// stalls, taken-branch and jump flushes, and freezes the pipe during
// multi-cycle data-memory accesses with a timeout into a sticky ERROR state.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : pipeline_hazard_ctrl_if.master (decoder inputs, register enables,
//           mem_err flag, saturating stall_cycles counter)
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   pipeline_hazard_ctrl_if.master bus
);
   localparam int              TO_W    = $clog2(MEM_TIMEOUT);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   ctrlState_e       state, stateNext;
   logic [TO_W-1:0]  toCnt;
   logic [CNT_W-1:0] stallCnt;
   logic             memErr;
   logic             luHit;
   logic             isJump;
   pipeCtrl_t        ctl;

   lu_hazard_cmp uLuCmp (
      .instr   (bus.if_id_instr),
      .idExRt  (bus.id_ex_rt),
      .memRead (bus.id_ex_memread),
      .hit     (luHit)
   );

   assign isJump = (opcodeOf(bus.if_id_instr) == OP_J) ||
                   (opcodeOf(bus.if_id_instr) == OP_JAL);

   always_comb begin
      ctl       = '0;
      stateNext = state;
      if (reset) begin
         ctl.ifIdFlush   = 1'b1;
         ctl.idExBubble  = 1'b1;
         ctl.memWbBubble = 1'b1;
         stateNext       = ST_RUN;
      end else begin
         case (state)
            ST_RUN: begin
               ctl.dmemReq = bus.ex_mem_access;
               // A pending memory access outranks everything: the pipe freezes,
               // so branch/jump/load-use inputs stay put and are handled later.
               if (bus.ex_mem_access && !bus.dmem_ready) begin
                  ctl.pipeHold    = 1'b1;
                  ctl.memWbBubble = 1'b1;
                  stateNext       = ST_MEM_WAIT;
               end else if (bus.ex_branch_taken) begin
                  ctl.pcWrite    = 1'b1;
                  ctl.ifIdFlush  = 1'b1;
                  ctl.idExBubble = 1'b1;
               end else if (luHit) begin
                  ctl.idExBubble = 1'b1;
               end else if (isJump) begin
                  ctl.pcWrite   = 1'b1;
                  ctl.ifIdFlush = 1'b1;
               end else begin
                  ctl.pcWrite   = 1'b1;
                  ctl.ifIdWrite = 1'b1;
               end
            end
            ST_MEM_WAIT: begin
               ctl.dmemReq = 1'b1;
               // Ready wins over the timeout on the last allowed cycle.
               if (bus.dmem_ready) begin
                  ctl.pcWrite   = 1'b1;
                  ctl.ifIdWrite = 1'b1;
                  stateNext     = ST_RUN;
               end else begin
                  ctl.pipeHold    = 1'b1;
                  ctl.memWbBubble = 1'b1;
                  if (toCnt == TO_LAST) stateNext = ST_ERROR;
               end
            end
            default: begin
               // ERROR (and the unused encoding): everything frozen, no requests.
               ctl.pipeHold    = 1'b1;
               ctl.memWbBubble = 1'b1;
               stateNext       = ST_ERROR;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_RUN;
         toCnt    <= '0;
         stallCnt <= '0;
         memErr   <= 1'b0;
      end else begin
         state <= stateNext;
         toCnt <= ((state == ST_MEM_WAIT) && (stateNext == ST_MEM_WAIT)) ?
                  toCnt + 1'b1 : '0;
         if (stateNext == ST_ERROR) memErr <= 1'b1;
         if (!ctl.pcWrite && (stallCnt != '1)) stallCnt <= stallCnt + 1'b1;
      end
   end

   assign bus.pc_write      = ctl.pcWrite;
   assign bus.if_id_write   = ctl.ifIdWrite;
   assign bus.if_id_flush   = ctl.ifIdFlush;
   assign bus.id_ex_bubble  = ctl.idExBubble;
   assign bus.pipe_hold     = ctl.pipeHold;
   assign bus.mem_wb_bubble = ctl.memWbBubble;
   assign bus.dmem_req      = ctl.dmemReq;
   assign bus.mem_err       = memErr;
   assign bus.stall_cycles  = stallCnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a behavioural
// model that tracks "waiting on memory", "cycles waited", "errored" and a
// saturating stall tally.
module tb_pipeline_hazard_ctrl;
   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 4;
   localparam int SAT         = (1 << CNT_W) - 1;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // reference model state
   bit mWaiting, mErrored;
   int mWaited, mStalls;

   pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [15:0] mkInstr(input int op, input int rs, input int rt, input int rd);
      return 16'((op << 12) + (rs << 9) + (rt << 6) + (rd << 3));
   endfunction

   // One clock cycle: drive inputs, compare at negedge, advance the model.
   // Control vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble,
   //                        pipe_hold, mem_wb_bubble, dmem_req}
   task automatic step(input bit r, input logic [15:0] ins, input bit mr,
                       input logic [2:0] rt, input bit br, input bit ma, input bit rdy);
      logic [6:0] expCtl, gotCtl;
      int op, rsF, rtF;
      bit luse, jump;
      reset = r;
      bus.if_id_instr = ins;
      bus.id_ex_memread = mr;
      bus.id_ex_rt = rt;
      bus.ex_branch_taken = br;
      bus.ex_mem_access = ma;
      bus.dmem_ready = rdy;
      @(negedge clock);
      op  = int'(ins) / 4096;
      rsF = (int'(ins) / 512) % 8;
      rtF = (int'(ins) / 64) % 8;
      luse = (ins != 0) && mr && (rt != 0) &&
             ((int'(rt) == rsF) || ((int'(rt) == rtF) && (op == 0 || op == 2 || op == 6)));
      jump = (op == 7) || (op == 8);
      if (r)                  expCtl = 7'b0011010;
      else if (mErrored)      expCtl = 7'b0000110;
      else if (mWaiting)      expCtl = rdy ? 7'b1100001 : 7'b0000111;
      else if (ma && !rdy)    expCtl = 7'b0000111;
      else if (br)            expCtl = {6'b101100, ma};
      else if (luse)          expCtl = {6'b000100, ma};
      else if (jump)          expCtl = {6'b101000, ma};
      else                    expCtl = {6'b110000, ma};
      gotCtl = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble,
                bus.pipe_hold, bus.mem_wb_bubble, bus.dmem_req};
      checkVal("ctl", 32'(gotCtl), 32'(expCtl));
      checkVal("mem_err", 32'(bus.mem_err), 32'(mErrored));
      checkVal("stall_cycles", 32'(bus.stall_cycles), 32'(mStalls));
      if (r) begin
         mWaiting = 0; mErrored = 0; mWaited = 0; mStalls = 0;
      end else begin
         if (!expCtl[6] && mStalls < SAT) mStalls++;
         if (mErrored) begin
         end else if (mWaiting) begin
            if (rdy) begin
               mWaiting = 0; mWaited = 0;
            end else begin
               mWaited++;
               if (mWaited == MEM_TIMEOUT) begin mErrored = 1; mWaiting = 0; end
            end
         end else if (ma && !rdy) begin
            mWaiting = 1; mWaited = 0;
         end
      end
      @(posedge clock);
      #1;
      cyc++;
   endtask

   initial begin : main
      logic [15:0] addUse, addR0, swUse, jal, plain, ins;
      int ops[7] = '{0, 2, 3, 5, 6, 7, 8};
      mWaiting = 0; mErrored = 0; mWaited = 0; mStalls = 0;
      addUse = mkInstr(0, 1, 2, 3);   // ADD r3, r1, r2
      addR0  = mkInstr(0, 0, 2, 3);   // reads r0 as rs
      swUse  = mkInstr(6, 4, 2, 0);   // SW with rt = r2
      jal    = mkInstr(8, 1, 2, 3);
      plain  = mkInstr(3, 4, 5, 0);   // ADDI, no overlap with r1/r2
      reset = 1'b1;
      @(posedge clock); #1;

      // reset state
      step(1, plain, 0, 0, 0, 0, 0);
      step(1, plain, 0, 0, 0, 0, 0);

      // load-use: one stall, then the load has moved on
      step(0, addUse, 1, 3'd1, 0, 0, 0);
      step(0, addUse, 0, 3'd0, 0, 0, 0);
      checkVal("stall_after_lu", 32'(bus.stall_cycles), 32'd1);

      // LW r0 never stalls; SW rt match does
      step(0, addR0, 1, 3'd0, 0, 0, 0);
      step(0, swUse, 1, 3'd2, 0, 0, 0);
      step(0, plain, 0, 3'd0, 0, 0, 0);

      // branch outranks load-use
      step(0, addUse, 1, 3'd1, 1, 0, 0);

      // JAL flushes; NOP does nothing even with a live load in EX
      step(0, jal, 0, 3'd0, 0, 0, 0);
      step(0, 16'h0000, 1, 3'd3, 0, 0, 0);

      // zero-wait access passes through; then a 3-cycle access
      step(0, plain, 0, 3'd0, 0, 1, 1);
      step(0, addUse, 1, 3'd1, 1, 1, 0);
      step(0, addUse, 1, 3'd1, 1, 1, 0);
      step(0, addUse, 1, 3'd1, 1, 1, 1);
      step(0, addUse, 1, 3'd1, 1, 0, 0);
      step(0, plain, 0, 3'd0, 0, 0, 0);

      // timeout into ERROR, sticky
      step(0, plain, 0, 3'd0, 0, 1, 0);
      for (int i = 0; i < MEM_TIMEOUT; i++) step(0, plain, 0, 3'd0, 0, 1, 0);
      step(0, plain, 0, 3'd0, 0, 1, 1);
      step(0, jal, 0, 3'd0, 1, 0, 0);
      checkVal("mem_err_sticky", 32'(bus.mem_err), 32'd1);

      // ready on the last allowed wait cycle wins
      step(1, plain, 0, 3'd0, 0, 0, 0);
      step(0, plain, 0, 3'd0, 0, 1, 0);
      for (int i = 0; i < MEM_TIMEOUT - 1; i++) step(0, plain, 0, 3'd0, 0, 1, 0);
      step(0, plain, 0, 3'd0, 0, 1, 1);
      step(0, plain, 0, 3'd0, 0, 0, 0);

      // reset mid-wait
      step(0, plain, 0, 3'd0, 0, 1, 0);
      step(0, plain, 0, 3'd0, 0, 1, 0);
      step(1, plain, 0, 3'd0, 0, 1, 0);
      step(0, plain, 0, 3'd0, 0, 0, 0);

      // stall counter saturation
      for (int i = 0; i < SAT + 5; i++) step(0, addUse, 1, 3'd1, 0, 0, 0);
      checkVal("stall_saturate", 32'(bus.stall_cycles), 32'(SAT));

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(9) == 0) ins = 16'h0000;
         else ins = mkInstr(ops[$urandom_range(6)], int'($urandom_range(7)),
                            int'($urandom_range(7)), int'($urandom_range(7)));
         step(($urandom_range(49) == 0), ins, ($urandom_range(2) == 0),
              3'($urandom_range(7)), ($urandom_range(6) == 0),
              ($urandom_range(4) == 0), ($urandom_range(1) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
